id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
- Registered decode/control stage for the pipelined RV32I core, sitting between the IF/ID and ID/EX registers.
- Fully decodes the instruction in ID and detects load-use hazards with a per-register countdown scoreboard.
- Issues decoded control into a valid/ready ID/EX register, with stall and flush.
- Generalises the core's combinational controller:
  - full RV32I decode (slt/sltu, unsigned branches, byte/half memory, auipc)
  - parametrised load latency and PC width
  - handshake-based stall/flush

Parameters:
- PC_W, 32, width of PC carried to EX.
- LOAD_LAT, 1, cycles a load's rd stays unavailable after issue (1..7).
- NREG, 32, architectural register count (16 for RV32E-style builds; rs/rd indices ≥ NREG flag illegal).

Ports:
- cpu_clk  in  1  clock, all state on rising edge.
- cpu_rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds an instruction.
- id_inst  in  32  instruction word.
- id_pc  in  PC_W  instruction PC.
- id_ready  out  1  instruction accepted this cycle when id_valid&&id_ready.
- ex_ready  in  1  EX consumes ID/EX register this cycle.
- flush  in  1  branch/jump redirect from EX; kills ID/EX contents.
- ex_valid  out  1  ID/EX register holds a live instruction.
- ex_pc  out  PC_W  registered PC.
- ex_rs1, ex_rs2, ex_rd  out  5 each  register indices (0 when unused).
- ex_alu_ctrl  out  5  ALU opcode.
- ex_op_b_sel  out  1  0=imm, 1=rD2.
- ex_sext_op  out  3  imm format: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J.
- ex_pc_sel  out  2  00 pc+4, 01 jal, 10 jalr, 11 branch.
- ex_wb_sel  out  2  00 ALU, 01 pc+4, 10 mem.
- ex_mem_write  out  1  store.
- ex_mem_size  out  3  funct3 of load/store, else 0.
- ex_reg_we  out  1  rd write enable, forced 0 when rd==0.
- ex_branch  out  1  branch/jal/jalr.
- ex_illegal  out  1  unrecognised encoding.

Behaviour:
- Reset: ex_valid and all ex_* outputs 0; all scoreboard counters 0. id_ready is combinational and is 0 during reset.
- ALU codes:
  - 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra
  - 8 beq, 9 bne, 10 blt, 11 bge, 12 bltu, 13 bgeu
  - 14 slt, 15 lui, 16 sltu, 17 auipc
  - 24–27 reserved for M-extension.
- Address ops: loads, stores and jalr use add with op_b_sel=0. Register read enables are derived internally: rs1 unused for lui/auipc/jal; rs2 used only for R, S and B formats.
- Hazard: asserted when id_valid, and a used source rsN≠0 has busy[rsN]≠0.
- id_ready = !cpu_rst && !flush && !hazard && (!ex_valid || ex_ready).
- Accept (id_valid&&id_ready): decoded fields are registered and ex_valid←1. Latency is 1 cycle from ID to ex_* outputs.
- No accept but ex_ready: ex_valid←0 (bubble). ex_valid && !ex_ready: all ex_* hold.
- Flush: ex_valid←0 next edge regardless of ex_ready; no accept that cycle. Scoreboard is not cleared; a killed load may cause extra stall cycles, which is acceptable.
- Scoreboard, per register:
  - On accept of a load with rd≠0: busy[rd]←LOAD_LAT.
  - Otherwise busy decrements by 1 each cycle while nonzero, saturating at 0.
  - A new load to the same rd overwrites the counter.
  - The load accepted this cycle does not decrement its own counter.
- Illegal: unknown opcode, unsupported funct3/funct7, or an index ≥ NREG. The instruction is still accepted with ex_illegal=1, reg_we=0, mem_write=0, branch=0, pc_sel=00. It creates no scoreboard entry.
- x0: rd==0 gives reg_we=0 and no scoreboard entry. Sources equal to 0 never hazard.
- cpu_rst mid-stall: everything returns to reset values next edge and pending hazards are dropped.

Optional Feature:
- Macro CTRL_MEXT_EN.
- When defined: opcode 0110011 with funct7=0000001 and funct3 0–3 decodes to mul/mulh/mulhsu/mulhu, ALU codes 24–27, op_b_sel=1, wb_sel=00, reg_we=1. funct3 4–7 (div family) are illegal.
- When undefined: every funct7=0000001 encoding is illegal.

Test Plan:
- Reset held 2 cycles, with id_valid=1 and id_inst=0x00228333 → ex_valid=0 and all ex_* 0 throughout. First post-reset edge: ex_valid=1, ex_alu_ctrl=0, ex_rd=6, ex_rs1=5, ex_rs2=2, ex_reg_we=1.
- LOAD_LAT=1: lw x5,0(x1) (0x0000A283) accepted at cycle N, then add x6,x5,x2 (0x00228333) presented at N+1 → id_ready=0 at N+1, accepted at N+2, ex_valid=0 (bubble) at N+2. Repeat with LOAD_LAT=2 → 2 stall cycles.
- ex_ready=0 for 3 cycles with ex_valid=1 → id_ready=0 and all ex_* stable. ex_ready=1 on cycle 4 → next instruction appears with no loss or duplication.
- flush=1 for one cycle while ex_valid=1 and id_valid=1 → id_ready=0 that cycle, ex_valid=0 next cycle. The held ID instruction is accepted the following cycle.
- bltu x1,x2,+8 (0x0020E463) → ex_alu_ctrl=12, ex_sext_op=3, ex_pc_sel=11, ex_branch=1, ex_reg_we=0. Opcode 0x0000007F → ex_illegal=1, ex_reg_we=0, ex_mem_write=0.
- mul x3,x1,x2 (0x022081B3) → with CTRL_MEXT_EN: ex_alu_ctrl=24, ex_illegal=0. Without it: ex_illegal=1, ex_reg_we=0.

Source files
------------

// File: rtl/id_ex_ctrl_stage.sv
// id_ex_ctrl_stage
//   Registered decode/control stage of the pipelined RV32I core. It decodes
//   the ID instruction, stalls on load-use hazards using a per-register
//   countdown scoreboard, and issues decoded control into a valid/ready
//   ID/EX register with stall and flush.
//
// Parameters
//   PC_W      width of the PC carried to EX
//   LOAD_LAT  cycles a load's rd stays unavailable after issue (1..7)
//   NREG      architectural register count; used indices >= NREG are illegal
//
// Optional build macro
//   CTRL_MEXT_EN  decode mul/mulh/mulhsu/mulhu (ALU codes 24..27)
//
// Ports
//   cpu_clk, cpu_rst          clock, synchronous active-high reset
//   id_valid/id_inst/id_pc    instruction presented by IF/ID
//   id_ready                  combinational accept (id_valid && id_ready)
//   ex_ready, flush           EX consume / redirect kill
//   ex_valid, ex_*            registered decoded control for EX
module id_ex_ctrl_stage #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned NREG     = 32
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            id_valid,
  input  logic [31:0]     id_inst,
  input  logic [PC_W-1:0] id_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  output logic            ex_valid,
  output logic [PC_W-1:0] ex_pc,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_alu_ctrl,
  output logic            ex_op_b_sel,
  output logic [2:0]      ex_sext_op,
  output logic [1:0]      ex_pc_sel,
  output logic [1:0]      ex_wb_sel,
  output logic            ex_mem_write,
  output logic [2:0]      ex_mem_size,
  output logic            ex_reg_we,
  output logic            ex_branch,
  output logic            ex_illegal
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_e;

  typedef enum logic [4:0] {
    ALU_ADD   = 5'd0,  ALU_SUB  = 5'd1,  ALU_AND  = 5'd2,  ALU_OR   = 5'd3,
    ALU_XOR   = 5'd4,  ALU_SLL  = 5'd5,  ALU_SRL  = 5'd6,  ALU_SRA  = 5'd7,
    ALU_BEQ   = 5'd8,  ALU_BNE  = 5'd9,  ALU_BLT  = 5'd10, ALU_BGE  = 5'd11,
    ALU_BLTU  = 5'd12, ALU_BGEU = 5'd13, ALU_SLT  = 5'd14, ALU_LUI  = 5'd15,
    ALU_SLTU  = 5'd16, ALU_AUIPC = 5'd17
  } alu_e;

  localparam logic [5:0] NREG6 = 6'(NREG);
  localparam logic [2:0] LAT3  = 3'(LOAD_LAT);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1, rs2, rd;

  assign opc = id_inst[6:0];
  assign rd  = id_inst[11:7];
  assign f3  = id_inst[14:12];
  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];
  assign f7  = id_inst[31:25];

  logic       d_illegal, d_opb, d_memw, d_we, d_br;
  logic [4:0] d_alu;
  logic [2:0] d_sext, d_msz;
  logic [1:0] d_pcsel, d_wb;
  logic       use1, use2, used, is_load;

  always_comb begin
    d_illegal = 1'b0;
    d_alu     = ALU_ADD;
    d_opb     = 1'b0;
    d_sext    = 3'd0;
    d_pcsel   = 2'b00;
    d_wb      = 2'b00;
    d_memw    = 1'b0;
    d_msz     = 3'd0;
    d_we      = 1'b0;
    d_br      = 1'b0;
    use1      = 1'b0;
    use2      = 1'b0;
    used      = 1'b0;
    is_load   = 1'b0;
    case (opc)
      OP_R: begin
        use1 = 1'b1; use2 = 1'b1; used = 1'b1; d_opb = 1'b1; d_we = 1'b1;
        case (f7)
          7'b0000000: begin
            case (f3)
              3'd0: d_alu = ALU_ADD;
              3'd1: d_alu = ALU_SLL;
              3'd2: d_alu = ALU_SLT;
              3'd3: d_alu = ALU_SLTU;
              3'd4: d_alu = ALU_XOR;
              3'd5: d_alu = ALU_SRL;
              3'd6: d_alu = ALU_OR;
              default: d_alu = ALU_AND;
            endcase
          end
          7'b0100000: begin
            if (f3 == 3'd0)      d_alu = ALU_SUB;
            else if (f3 == 3'd5) d_alu = ALU_SRA;
            else                 d_illegal = 1'b1;
          end
`ifdef CTRL_MEXT_EN
          7'b0000001: begin
            if (!f3[2]) d_alu = {3'b110, f3[1:0]};
            else        d_illegal = 1'b1;
          end
`endif
          default: d_illegal = 1'b1;
        endcase
      end
      OP_I: begin
        use1 = 1'b1; used = 1'b1; d_sext = 3'd1; d_we = 1'b1;
        case (f3)
          3'd0: d_alu = ALU_ADD;
          3'd2: d_alu = ALU_SLT;
          3'd3: d_alu = ALU_SLTU;
          3'd4: d_alu = ALU_XOR;
          3'd6: d_alu = ALU_OR;
          3'd7: d_alu = ALU_AND;
          3'd1: begin
            d_alu = ALU_SLL;
            if (f7 != 7'b0000000) d_illegal = 1'b1;
          end
          default: begin
            if (f7 == 7'b0000000)      d_alu = ALU_SRL;
            else if (f7 == 7'b0100000) d_alu = ALU_SRA;
            else                       d_illegal = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        use1 = 1'b1; used = 1'b1; d_sext = 3'd1; d_wb = 2'b10; d_msz = f3;
        d_we = 1'b1; is_load = 1'b1;
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) d_illegal = 1'b1;
      end
      OP_STORE: begin
        use1 = 1'b1; use2 = 1'b1; d_sext = 3'd2; d_memw = 1'b1; d_msz = f3;
        if (f3 > 3'd2) d_illegal = 1'b1;
      end
      OP_BRANCH: begin
        use1 = 1'b1; use2 = 1'b1; d_opb = 1'b1; d_sext = 3'd3;
        d_pcsel = 2'b11; d_br = 1'b1;
        case (f3)
          3'd0: d_alu = ALU_BEQ;
          3'd1: d_alu = ALU_BNE;
          3'd4: d_alu = ALU_BLT;
          3'd5: d_alu = ALU_BGE;
          3'd6: d_alu = ALU_BLTU;
          3'd7: d_alu = ALU_BGEU;
          default: d_illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        used = 1'b1; d_we = 1'b1; d_sext = 3'd4; d_alu = ALU_LUI;
      end
      OP_AUIPC: begin
        used = 1'b1; d_we = 1'b1; d_sext = 3'd4; d_alu = ALU_AUIPC;
      end
      OP_JAL: begin
        used = 1'b1; d_we = 1'b1; d_sext = 3'd5; d_pcsel = 2'b01;
        d_wb = 2'b01; d_br = 1'b1;
      end
      OP_JALR: begin
        use1 = 1'b1; used = 1'b1; d_we = 1'b1; d_sext = 3'd1;
        d_pcsel = 2'b10; d_wb = 2'b01; d_br = 1'b1;
        if (f3 != 3'd0) d_illegal = 1'b1;
      end
      default: d_illegal = 1'b1;
    endcase
  end

  logic idx_bad, legal;
  assign idx_bad = (use1 && ({1'b0, rs1} >= NREG6)) ||
                   (use2 && ({1'b0, rs2} >= NREG6)) ||
                   (used && ({1'b0, rd}  >= NREG6));
  assign legal = !d_illegal && !idx_bad;

  // One counter per index; entries at or above NREG are never loaded and
  // stay at zero. Illegal instructions neither hazard nor create entries,
  // which also keeps out-of-range indices away from the array.
  logic [2:0] busy [32];
  logic       hazard, accept, ld_set;

  assign hazard = id_valid && legal &&
                  ((use1 && (rs1 != 5'd0) && (busy[rs1] != 3'd0)) ||
                   (use2 && (rs2 != 5'd0) && (busy[rs2] != 3'd0)));
  assign id_ready = !cpu_rst && !flush && !hazard && (!ex_valid || ex_ready);
  assign accept   = id_valid && id_ready;
  assign ld_set   = accept && legal && is_load && (rd != 5'd0);

  always_ff @(posedge cpu_clk) begin
    for (int unsigned r = 0; r < 32; r++) begin
      if (cpu_rst)
        busy[r[4:0]] <= '0;
      else if (ld_set && (rd == r[4:0]))
        busy[r[4:0]] <= LAT3;
      else if (busy[r[4:0]] != '0)
        busy[r[4:0]] <= busy[r[4:0]] - 3'd1;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_alu_ctrl  <= '0;
      ex_op_b_sel  <= 1'b0;
      ex_sext_op   <= '0;
      ex_pc_sel    <= '0;
      ex_wb_sel    <= '0;
      ex_mem_write <= 1'b0;
      ex_mem_size  <= '0;
      ex_reg_we    <= 1'b0;
      ex_branch    <= 1'b0;
      ex_illegal   <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (accept) begin
      ex_valid     <= 1'b1;
      ex_pc        <= id_pc;
      ex_rs1       <= (legal && use1) ? rs1 : '0;
      ex_rs2       <= (legal && use2) ? rs2 : '0;
      ex_rd        <= (legal && used) ? rd  : '0;
      ex_alu_ctrl  <= legal ? d_alu   : '0;
      ex_op_b_sel  <= legal && d_opb;
      ex_sext_op   <= legal ? d_sext  : '0;
      ex_pc_sel    <= legal ? d_pcsel : '0;
      ex_wb_sel    <= legal ? d_wb    : '0;
      ex_mem_write <= legal && d_memw;
      ex_mem_size  <= legal ? d_msz   : '0;
      ex_reg_we    <= legal && d_we && (rd != 5'd0);
      ex_branch    <= legal && d_br;
      ex_illegal   <= !legal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// tb_id_ex_ctrl_stage
//   Scoreboard bench for id_ex_ctrl_stage (LOAD_LAT=2, NREG=16). The driver
//   decodes each issued instruction with a mask/match instruction table and
//   pushes the expected ID/EX contents; a separate monitor compares the head
//   of the queue whenever ex_valid is high. Load-use availability is modelled
//   as "register free from cycle N"; id_ready is checked every cycle.
module tb_id_ex_ctrl_stage;

  localparam int LAT  = 2;
  localparam int NREG = 16;

  logic        clk;
  logic        cpu_rst, id_valid, ex_ready, flush;
  logic [31:0] id_inst, id_pc;
  logic        id_ready, ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl;
  logic        ex_op_b_sel, ex_mem_write, ex_reg_we, ex_branch, ex_illegal;
  logic [2:0]  ex_sext_op, ex_mem_size;
  logic [1:0]  ex_pc_sel, ex_wb_sel;

  id_ex_ctrl_stage #(.PC_W(32), .LOAD_LAT(LAT), .NREG(NREG)) dut (
    .cpu_clk(clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_ready(id_ready), .ex_ready(ex_ready), .flush(flush),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_alu_ctrl(ex_alu_ctrl), .ex_op_b_sel(ex_op_b_sel),
    .ex_sext_op(ex_sext_op), .ex_pc_sel(ex_pc_sel), .ex_wb_sel(ex_wb_sel),
    .ex_mem_write(ex_mem_write), .ex_mem_size(ex_mem_size),
    .ex_reg_we(ex_reg_we), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        illegal;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd, alu;
    logic        opb;
    logic [2:0]  sext;
    logic [1:0]  pcsel, wb;
    logic        memw;
    logic [2:0]  msz;
    logic        we, br;
  } exp_t;

  typedef enum int { K_R, K_I, K_L, K_S, K_B, K_U, K_J, K_JR } kind_e;
  typedef struct { logic [31:0] mask; logic [31:0] match; kind_e kind; logic [4:0] alu; } ent_t;

  ent_t tab[$];
  exp_t q[$];
  int   free_at[32];
  int   cyc = 0;
  bit   m_full = 0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] M_R = 32'hFE00707F, M_F3 = 32'h0000707F, M_OP = 32'h0000007F;

  task automatic add_ent(input logic [31:0] m, input logic [31:0] x, input kind_e k, input int a);
    ent_t t;
    t.mask = m; t.match = x; t.kind = k; t.alu = 5'(a);
    tab.push_back(t);
  endtask

  task automatic build_table();
    add_ent(M_R, 32'h00000033, K_R, 0);  add_ent(M_R, 32'h40000033, K_R, 1);
    add_ent(M_R, 32'h00001033, K_R, 5);  add_ent(M_R, 32'h00002033, K_R, 14);
    add_ent(M_R, 32'h00003033, K_R, 16); add_ent(M_R, 32'h00004033, K_R, 4);
    add_ent(M_R, 32'h00005033, K_R, 6);  add_ent(M_R, 32'h40005033, K_R, 7);
    add_ent(M_R, 32'h00006033, K_R, 3);  add_ent(M_R, 32'h00007033, K_R, 2);
`ifdef CTRL_MEXT_EN
    add_ent(M_R, 32'h02000033, K_R, 24); add_ent(M_R, 32'h02001033, K_R, 25);
    add_ent(M_R, 32'h02002033, K_R, 26); add_ent(M_R, 32'h02003033, K_R, 27);
`endif
    add_ent(M_F3, 32'h00000013, K_I, 0);  add_ent(M_F3, 32'h00002013, K_I, 14);
    add_ent(M_F3, 32'h00003013, K_I, 16); add_ent(M_F3, 32'h00004013, K_I, 4);
    add_ent(M_F3, 32'h00006013, K_I, 3);  add_ent(M_F3, 32'h00007013, K_I, 2);
    add_ent(M_R, 32'h00001013, K_I, 5);   add_ent(M_R, 32'h00005013, K_I, 6);
    add_ent(M_R, 32'h40005013, K_I, 7);
    add_ent(M_F3, 32'h00000003, K_L, 0);  add_ent(M_F3, 32'h00001003, K_L, 0);
    add_ent(M_F3, 32'h00002003, K_L, 0);  add_ent(M_F3, 32'h00004003, K_L, 0);
    add_ent(M_F3, 32'h00005003, K_L, 0);
    add_ent(M_F3, 32'h00000023, K_S, 0);  add_ent(M_F3, 32'h00001023, K_S, 0);
    add_ent(M_F3, 32'h00002023, K_S, 0);
    add_ent(M_F3, 32'h00000063, K_B, 8);  add_ent(M_F3, 32'h00001063, K_B, 9);
    add_ent(M_F3, 32'h00004063, K_B, 10); add_ent(M_F3, 32'h00005063, K_B, 11);
    add_ent(M_F3, 32'h00006063, K_B, 12); add_ent(M_F3, 32'h00007063, K_B, 13);
    add_ent(M_OP, 32'h00000037, K_U, 15); add_ent(M_OP, 32'h00000017, K_U, 17);
    add_ent(M_OP, 32'h0000006F, K_J, 0);  add_ent(M_F3, 32'h00000067, K_JR, 0);
  endtask

  function automatic void ref_decode(input logic [31:0] inst, input logic [31:0] pc,
                                     output exp_t e, output bit ld);
    int    hit;
    kind_e k;
    bit    u1, u2, ud;
    logic [4:0] r1, r2, rd;
    hit = -1;
    foreach (tab[i]) if ((inst & tab[i].mask) == tab[i].match) hit = i;
    e = '0; e.pc = pc; ld = 0;
    if (hit < 0) begin e.illegal = 1'b1; return; end
    k  = tab[hit].kind;
    r1 = inst[19:15]; r2 = inst[24:20]; rd = inst[11:7];
    u1 = !(k inside {K_U, K_J});
    u2 = k inside {K_R, K_S, K_B};
    ud = !(k inside {K_S, K_B});
    if ((u1 && int'(r1) >= NREG) || (u2 && int'(r2) >= NREG) || (ud && int'(rd) >= NREG)) begin
      e.illegal = 1'b1; return;
    end
    e.rs1 = u1 ? r1 : 5'd0;
    e.rs2 = u2 ? r2 : 5'd0;
    e.rd  = ud ? rd : 5'd0;
    e.alu = tab[hit].alu;
    case (k)
      K_R:  e.opb = 1'b1;
      K_I:  e.sext = 3'd1;
      K_L:  begin e.sext = 3'd1; e.wb = 2'd2; e.msz = inst[14:12]; end
      K_S:  begin e.sext = 3'd2; e.memw = 1'b1; e.msz = inst[14:12]; end
      K_B:  begin e.opb = 1'b1; e.sext = 3'd3; e.pcsel = 2'd3; e.br = 1'b1; end
      K_U:  e.sext = 3'd4;
      K_J:  begin e.sext = 3'd5; e.pcsel = 2'd1; e.wb = 2'd1; e.br = 1'b1; end
      default: begin e.sext = 3'd1; e.pcsel = 2'd2; e.wb = 2'd1; e.br = 1'b1; end
    endcase
    e.we = ud && (rd != 5'd0);
    ld   = (k == K_L) && (rd != 5'd0);
  endfunction

  function automatic exp_t act();
    return {ex_illegal, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_alu_ctrl, ex_op_b_sel,
            ex_sext_op, ex_pc_sel, ex_wb_sel, ex_mem_write, ex_mem_size,
            ex_reg_we, ex_branch};
  endfunction

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, a, x, $time);
    end
  endtask

  // One clock cycle: drive at posedge+2, check id_ready at +3, update the
  // model at the following posedge.
  task automatic cycle(input bit rs, input bit v, input logic [31:0] inst,
                       input logic [31:0] pc, input bit rdy, input bit fl,
                       output bit acc, output bit dacc);
    exp_t e;
    bit   ld, haz, mr;
    cpu_rst = rs; id_valid = v; id_inst = inst; id_pc = pc; ex_ready = rdy; flush = fl;
    ref_decode(inst, pc, e, ld);
    haz = v && ((e.rs1 != 0 && cyc < free_at[e.rs1]) || (e.rs2 != 0 && cyc < free_at[e.rs2]));
    mr  = !rs && !fl && !haz && (!m_full || rdy);
    #1;
    chk("id_ready", 128'(id_ready), 128'(mr));
    dacc = id_valid && id_ready;
    @(posedge clk);
    acc = v && mr;
    if (rs) begin
      m_full = 0;
      q.delete();
      foreach (free_at[i]) free_at[i] = 0;
    end else if (fl) begin
      m_full = 0;
    end else if (acc) begin
      q.push_back(e);
      m_full = 1;
      if (ld) free_at[e.rd] = cyc + LAT + 1;
    end else if (rdy) begin
      m_full = 0;
    end
    cyc++;
    #2;
  endtask

  task automatic issue(input logic [31:0] inst, output int n);
    bit acc, dacc;
    logic [31:0] pc;
    pc = $urandom & 32'hFFFF_FFFC;
    n = 0; dacc = 0;
    while (!dacc && n < 20) begin
      cycle(0, 1, inst, pc, 1, 0, acc, dacc);
      n++;
    end
    if (!dacc) begin
      checks++; errors++;
      $display("FAIL issue_timeout: inst %h not accepted in %0d cycles, expected acceptance", inst, n);
    end
  endtask

  function automatic logic [4:0] rreg();
    if ($urandom_range(0, 23) == 0) return 5'($urandom_range(16, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] gen();
    logic [31:0] w;
    ent_t t;
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 3) return 32'h0000007F;
    if (r < 6) return $urandom;
    do t = tab[$urandom_range(0, tab.size() - 1)]; while (r < 30 && t.kind != K_L);
    w = $urandom;
    w[11:7] = rreg(); w[19:15] = rreg(); w[24:20] = rreg();
    return (w & ~t.mask) | t.match;
  endfunction

  // Monitor: compare the ID/EX register against the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      if (cpu_rst === 1'b0) begin
        chk("ex_valid", 128'(ex_valid), 128'(q.size() != 0));
        if (ex_valid && q.size() != 0) begin
          chk("ex_fields", 128'(act()), 128'(q[0]));
          if (ex_ready || flush) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc, dacc, hold;
    int n;
    logic [31:0] cur, cur_pc;
    build_table();
    foreach (free_at[i]) free_at[i] = 0;

    // reset held two cycles with an instruction presented
    for (int i = 0; i < 2; i++) begin
      cycle(1, 1, 32'h00228333, 32'h100, 1, 0, acc, dacc);
      chk("reset_state", 128'({ex_valid, act()}), 128'(0));
    end
    cycle(0, 1, 32'h00228333, 32'h100, 1, 0, acc, dacc);
    chk("post_reset", 128'({ex_valid, ex_alu_ctrl, ex_rd, ex_rs1, ex_rs2, ex_reg_we}),
        128'({1'b1, 5'd0, 5'd6, 5'd5, 5'd2, 1'b1}));

    // load-use stall: LAT stall cycles then accept
    issue(32'h0000A283, n);
    issue(32'h00228333, n);
    chk("load_use_cycles", 128'(n), 128'(LAT + 1));

    // EX backpressure for 3 cycles
    issue(32'h0020A023, n);
    for (int i = 0; i < 3; i++) cycle(0, 1, 32'h008000EF, 32'h200, 0, 0, acc, dacc);
    issue(32'h008000EF, n);
    chk("after_stall_cycles", 128'(n), 128'(1));

    // flush kills ID/EX, held instruction accepted next cycle
    issue(32'h000123B7, n);
    cycle(0, 1, 32'h00000013, 32'h300, 1, 1, acc, dacc);
    issue(32'h00000013, n);
    chk("after_flush_cycles", 128'(n), 128'(1));

    issue(32'h0020E463, n);
    chk("bltu", 128'({ex_alu_ctrl, ex_sext_op, ex_pc_sel, ex_branch, ex_reg_we}),
        128'({5'd12, 3'd3, 2'b11, 1'b1, 1'b0}));
    issue(32'h0000007F, n);
    chk("bad_opcode", 128'({ex_illegal, ex_reg_we, ex_mem_write}), 128'(3'b100));
    issue(32'h022081B3, n);
`ifdef CTRL_MEXT_EN
    chk("mul", 128'({ex_alu_ctrl, ex_illegal}), 128'({5'd24, 1'b0}));
`else
    chk("mul", 128'({ex_illegal, ex_reg_we}), 128'(2'b10));
`endif

    // reset in the middle of a load-use stall drops the hazard
    issue(32'h0000A283, n);
    cycle(0, 1, 32'h00228333, 32'h400, 1, 0, acc, dacc);
    cycle(1, 1, 32'h00228333, 32'h400, 1, 0, acc, dacc);
    issue(32'h00228333, n);
    chk("reset_drops_hazard", 128'(n), 128'(1));

    // randomized traffic
    hold = 0; cur = 32'h13; cur_pc = 0;
    for (int c = 0; c < 4000; c++) begin
      bit v, rdy, fl, rs;
      if (!hold || $urandom_range(0, 3) == 0) begin
        cur = gen();
        cur_pc = $urandom & 32'hFFFF_FFFC;
      end
      v   = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 9) < 7;
      fl  = $urandom_range(0, 15) == 0;
      rs  = $urandom_range(0, 499) == 0;
      cycle(rs, v, cur, cur_pc, rdy, fl, acc, dacc);
      hold = v && !acc;
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 32'h0, 32'h0, 1, 0, acc, dacc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
